// File: rtl/ifetch_prefetch_if.sv
// Pipelined Wishbone B4 bundle for the instruction fetch bus.
// The controller side only reads: we is tied low, sel to all lanes.
interface wishbone;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;
  logic        stall;

  modport controller (
    output cyc, stb, we, adr, sel,
    input  dat_r, ack, err, stall
  );

  modport target (
    input  cyc, stb, we, adr, sel,
    output dat_r, ack, err, stall
  );
endinterface

// File: rtl/ifetch_prefetch.sv
// Sequential instruction prefetch queue on a pipelined Wishbone bus.
// Define IFETCH_FAULT_EN to expose o_fault and halt fetch on bus error.
module ifetch_prefetch #(
  parameter logic [31:0] INIT_PC = 32'h1000_0000,
  parameter int unsigned DEPTH   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  wishbone.controller wb,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_addr,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_ready
`ifdef IFETCH_FAULT_EN
  ,
  output logic        o_fault
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN,
    ABORT,
    HALT
  } state_e;

  typedef struct packed {
`ifdef IFETCH_FAULT_EN
    logic        fault;
`endif
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];

  logic          issue;
  logic          resp;
  logic          pop;
  logic [CW:0]   credit;
  logic [31:0]   redir_pc;
  entry_t        wr_entry;
  entry_t        head;

  assign redir_pc = i_redirect_addr & 32'hFFFF_FFFC;
  assign issue    = stb_q & ~wb.stall;
  assign resp     = cyc_q & (wb.ack | wb.err)
                  & (outst_q != '0);
  assign pop      = o_valid & i_ready;

  always_comb begin
    wr_entry    = '0;
    wr_entry.pc = resp_pc_q;
`ifdef IFETCH_FAULT_EN
    wr_entry.instr = wb.err ? 32'h0 : wb.dat_r;
    wr_entry.fault = wb.err;
`else
    wr_entry.instr = wb.err ? NOP : wb.dat_r;
`endif
  end

  always_comb begin
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    resp_pc_d = resp_pc_q;
    count_d   = count_q;
    outst_d   = outst_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_d     = mem_q;
    if (i_redirect) begin
      // Responses and the FIFO die here; a pop
      // this cycle still counts as consumed.
      state_d   = ABORT;
      req_pc_d  = redir_pc;
      resp_pc_d = redir_pc;
      count_d   = '0;
      outst_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
    end else begin
      if (state_q == ABORT) state_d = RUN;
      if (issue) begin
        req_pc_d = req_pc_q + 32'd4;
        outst_d  = outst_d + 1'b1;
      end
      if (resp) begin
        mem_d[wr_ptr_q] = wr_entry;
        wr_ptr_d  = wr_ptr_q + 1'b1;
        resp_pc_d = resp_pc_q + 32'd4;
        outst_d   = outst_d - 1'b1;
`ifdef IFETCH_FAULT_EN
        if (wb.err) state_d = HALT;
`endif
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(resp) - CW'(pop);
    end
  end

  // Bus strobes are registered, so derive
  // them from the next-state credit.
  always_comb begin
    credit = {1'b0, outst_d} + {1'b0, count_d};
    stb_d  = (state_d == RUN)
           && (credit < (CW+1)'(DEPTH));
    cyc_d  = stb_d
           || ((state_d != ABORT) && (outst_d != '0));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= RUN;
      req_pc_q  <= INIT_PC;
      resp_pc_q <= INIT_PC;
      count_q   <= '0;
      outst_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      resp_pc_q <= resp_pc_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
    end
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign head    = mem_q[rd_ptr_q];
  assign o_valid = (count_q != '0);
  assign o_instr = o_valid ? head.instr : 32'h0;
  assign o_pc    = o_valid ? head.pc : 32'h0;
`ifdef IFETCH_FAULT_EN
  assign o_fault = o_valid & head.fault;
`endif

  assign wb.cyc = cyc_q;
  assign wb.stb = stb_q;
  assign wb.adr = req_pc_q;
  assign wb.we  = 1'b0;
  assign wb.sel = 4'hF;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch with a latency-programmable
// Wishbone slave that returns the request address as data.
module tb_ifetch_prefetch;

  localparam logic [31:0] INIT_PC = 32'h1000_0000;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        ready;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
`ifdef IFETCH_FAULT_EN
  logic        fault;
  logic        got_f [$];
`endif

  always #5 clk = ~clk;

  wishbone wb ();

  ifetch_prefetch #(
    .INIT_PC(INIT_PC),
    .DEPTH(DEPTH)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .wb(wb),
    .i_redirect(redirect),
    .i_redirect_addr(redirect_addr),
    .o_valid(valid),
    .o_instr(instr),
    .o_pc(pc),
    .i_ready(ready)
`ifdef IFETCH_FAULT_EN
    ,
    .o_fault(fault)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  int          lat = 0;
  bit          err_en = 0;
  logic [31:0] err_adr = '0;
  bit          stall_req = 0;
  int          n_issued;

  logic [31:0] sq_a [$];
  int          sq_d [$];
  logic [31:0] got_pc [$];
  logic [31:0] got_in [$];

  // Slave: decides at negedge what the next posedge samples.
  initial begin
    wb.ack   = 1'b0;
    wb.err   = 1'b0;
    wb.dat_r = '0;
    wb.stall = 1'b0;
    n_issued = 0;
    forever begin
      @(negedge clk);
      wb.ack   = 1'b0;
      wb.err   = 1'b0;
      wb.dat_r = '0;
      wb.stall = stall_req;
      if (!rst_n) n_issued = 0;
      if (!rst_n || !wb.cyc) begin
        sq_a.delete();
        sq_d.delete();
      end else begin
        if (sq_a.size() > 0 && sq_d[0] == 0) begin
          if (err_en && sq_a[0] == err_adr) begin
            wb.err = 1'b1;
          end else begin
            wb.ack   = 1'b1;
            wb.dat_r = sq_a[0];
          end
          void'(sq_a.pop_front());
          void'(sq_d.pop_front());
        end
        foreach (sq_d[i]) if (sq_d[i] > 0) sq_d[i]--;
        if (wb.stb && !wb.stall) begin
          sq_a.push_back(wb.adr);
          sq_d.push_back(lat);
          n_issued++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      got_pc.push_back(pc);
      got_in.push_back(instr);
`ifdef IFETCH_FAULT_EN
      got_f.push_back(fault);
`endif
    end
  end

  typedef struct {
    logic [31:0] addr;
    int          lat;
    int          n;
    logic [31:0] first;
  } vec_t;

  vec_t vecs [4];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  task automatic clear_got();
    got_pc.delete();
    got_in.delete();
`ifdef IFETCH_FAULT_EN
    got_f.delete();
`endif
  endtask

  function automatic logic [31:0] gpc(input int i);
    return (i < got_pc.size()) ? got_pc[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] gin(input int i);
    return (i < got_in.size()) ? got_in[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic wait_got(input string name, input int n,
                          output int cyc);
    cyc = 0;
    while (got_pc.size() < n && cyc < 300) begin
      tick(1);
      cyc++;
    end
    chk({name, "_cnt"}, 32'(got_pc.size() >= n), 32'd1);
  endtask

  task automatic chk_seq(input string name,
                         input logic [31:0] first,
                         input int n);
    logic [31:0] e;
    for (int i = 0; i < n; i++) begin
      e = first + 32'(4 * i);
      chk($sformatf("%s_pc%0d", name, i), gpc(i), e);
      chk($sformatf("%s_in%0d", name, i), gin(i), e);
    end
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    redirect = 1'b0;
    tick(2);
    clear_got();
  endtask

  int k;

  initial begin
    rst_n         = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    ready         = 1'b0;
    vecs[0] = '{32'h0000_1000, 3, 4, 32'h0000_1000};
    vecs[1] = '{32'h2000_0006, 3, 3, 32'h2000_0004};
    vecs[2] = '{32'hFFFF_FFF8, 0, 3, 32'hFFFF_FFF8};
    vecs[3] = '{32'h0000_0103, 1, 5, 32'h0000_0100};

    tick(2);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_cyc", 32'(wb.cyc), 32'd0);
    chk("rst_stb", 32'(wb.stb), 32'd0);
    chk("rst_adr", wb.adr, INIT_PC);
    chk("rst_we", 32'(wb.we), 32'd0);
    chk("rst_sel", 32'(wb.sel), 32'hF);
`ifdef IFETCH_FAULT_EN
    chk("rst_fault", 32'(fault), 32'd0);
`endif

    // Zero-wait streaming, one instruction per cycle.
    ready = 1'b1;
    rst_n = 1'b1;
    tick(1);
    chk("start_stb", 32'(wb.stb), 32'd1);
    chk("start_adr", wb.adr, INIT_PC);
    clear_got();
    wait_got("stream", 8, k);
    chk("tput_cycles", k, 32'd10);
    chk_seq("stream", INIT_PC, 8);

    for (int v = 0; v < 4; v++) begin
      lat           = vecs[v].lat;
      redirect_addr = vecs[v].addr;
      redirect      = 1'b1;
      tick(1);
      chk($sformatf("v%0d_cyc", v), 32'(wb.cyc), 32'd0);
      chk($sformatf("v%0d_valid", v), 32'(valid), 32'd0);
      redirect = 1'b0;
      clear_got();
      tick(1);
      chk($sformatf("v%0d_stb", v), 32'(wb.stb), 32'd1);
      chk($sformatf("v%0d_adr", v), wb.adr, vecs[v].first);
      wait_got($sformatf("v%0d", v), vecs[v].n, k);
      chk_seq($sformatf("v%0d", v), vecs[v].first, vecs[v].n);
    end

    // Stall then back-pressure: at most DEPTH reads.
    ready     = 1'b0;
    lat       = 0;
    stall_req = 1'b1;
    apply_reset();
    rst_n = 1'b1;
    tick(1);
    chk("stall_stb0", 32'(wb.stb), 32'd1);
    tick(3);
    chk("stall_stb1", 32'(wb.stb), 32'd1);
    chk("stall_adr", wb.adr, INIT_PC);
    chk("stall_issued", n_issued, 32'd0);
    stall_req = 1'b0;
    tick(12);
    chk("bp_issued", n_issued, 32'(DEPTH));
    chk("bp_stb", 32'(wb.stb), 32'd0);
    chk("bp_cyc", 32'(wb.cyc), 32'd0);
    chk("bp_valid", 32'(valid), 32'd1);
    chk("bp_pc", pc, INIT_PC);
    chk("bp_instr", instr, INIT_PC);
    clear_got();
    ready = 1'b1;
    wait_got("bp", 8, k);
    chk_seq("bp", INIT_PC, 8);

    // Bus error on the third fetch.
    err_en  = 1'b1;
    err_adr = INIT_PC + 32'h8;
    apply_reset();
    rst_n = 1'b1;
    tick(1);
`ifdef IFETCH_FAULT_EN
    wait_got("err", 3, k);
    chk("err_pc2", gpc(2), INIT_PC + 32'h8);
    chk("err_in2", gin(2), 32'h0);
    chk("err_f1", 32'(got_f.size() > 1 && got_f[1]), 32'd0);
    chk("err_f2", 32'(got_f.size() > 2 && got_f[2]), 32'd1);
    tick(6);
    chk("halt_stb", 32'(wb.stb), 32'd0);
    err_en        = 1'b0;
    redirect_addr = 32'h0000_3000;
    redirect      = 1'b1;
    tick(1);
    redirect = 1'b0;
    clear_got();
    wait_got("recover", 2, k);
    chk_seq("recover", 32'h0000_3000, 2);
`else
    wait_got("err", 4, k);
    chk("err_pc2", gpc(2), INIT_PC + 32'h8);
    chk("err_in2", gin(2), 32'h0000_0013);
    chk("err_pc3", gpc(3), INIT_PC + 32'hC);
    chk("err_in3", gin(3), INIT_PC + 32'hC);
`endif
    err_en = 1'b0;

    // Reset with three reads outstanding.
    ready = 1'b0;
    lat   = 3;
    apply_reset();
    rst_n = 1'b1;
    tick(1);
    tick(3);
    chk("mid_issued", n_issued, 32'd3);
    chk("mid_valid0", 32'(valid), 32'd0);
    rst_n = 1'b0;
    tick(1);
    chk("mid_cyc", 32'(wb.cyc), 32'd0);
    chk("mid_stb", 32'(wb.stb), 32'd0);
    chk("mid_adr", wb.adr, INIT_PC);
    chk("mid_valid", 32'(valid), 32'd0);
    chk("mid_pc", pc, 32'h0);
    chk("mid_instr", instr, 32'h0);
    lat   = 0;
    ready = 1'b1;
    rst_n = 1'b1;
    clear_got();
    tick(1);
    chk("refetch_stb", 32'(wb.stb), 32'd1);
    chk("refetch_adr", wb.adr, INIT_PC);
    wait_got("refetch", 2, k);
    chk_seq("refetch", INIT_PC, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
